// File: rtl/query_loader_pkg.sv
// query_loader_pkg
//   Shared definitions for the query_loader slice:
//     state_e          receive FSM states
//     SYNC_DEFAULT     default frame start byte
//     bytes_per_query  number of payload bytes carrying one query vector
package query_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_K,
    ST_PAYLOAD,
    ST_CHECK,
    ST_PRESENT
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int bytes_per_query(input int dim, input int word_w);
    return dim * (word_w / 8);
  endfunction

endpackage

// File: rtl/ql_timeout.sv
// ql_timeout
//   Inter-byte idle timer for the frame receiver. Reloaded on every byte,
//   counts down while enabled, and raises expire_o for one cycle once
//   TIMEOUT consecutive byte-free cycles have elapsed.
// Ports
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   en_i      count only while a frame is in progress
//   load_i    a byte was accepted this cycle: restart the idle window
//   expire_o  idle window exhausted (combinational, one cycle wide)
module ql_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded with TIMEOUT-1 on the byte edge, the count reaches zero in the
  // TIMEOUT-th idle cycle, so the FSM leaves the frame on the following edge.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/query_loader.sv
// query_loader
//   Receives framed bytes from the UART receiver, assembles a DIM-word query
//   and its k value, verifies the XOR checksum and k range, and presents the
//   committed query to the search core on a valid/ready handshake.
//   Frame: SYNC, k_lo, k_hi, DIM*BPW query bytes (word 0 first, LSB first), csum.
// Ports
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   byte_in          received byte
//   byte_valid_in    byte_in valid strobe
//   query_out        committed query words
//   k_out            committed k
//   query_valid_out  committed query is being presented
//   query_ready_in   consumer accepts the query
//   busy_out         frame reception in progress
//   err_out          one-cycle pulse on checksum, k-range or timeout error
//   drop_cnt_out     bytes discarded while presenting (saturating)
module query_loader
  import query_loader_pkg::*;
#(
  parameter int         DIM     = 4,
  parameter int         WORD_W  = 32,
  parameter int         MAX_K   = 8,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 50000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  output logic [WORD_W-1:0] query_out [DIM],
  output logic [15:0]       k_out,
  output logic              query_valid_out,
  input  logic              query_ready_in,
  output logic              busy_out,
  output logic              err_out,
  output logic [7:0]        drop_cnt_out
);

  localparam int BPW    = WORD_W / 8;
  localparam int NBYTES = bytes_per_query(DIM, WORD_W);
  localparam int IDX_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_KHI  = IDX_W'(1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        xor_q, xor_d;
  logic              err_q, err_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       k_sh_q;
  logic [WORD_W-1:0] q_sh_q [DIM];
  logic [15:0]       k_out_q;
  logic [WORD_W-1:0] q_out_q [DIM];

  logic in_frame;
  logic expire;
  logic pass;
  logic commit;

  assign in_frame = (state_q == ST_K) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  ql_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .en_i     (in_frame),
    .load_i   (byte_valid_in),
    .expire_o (expire)
  );

  // The k shadow is complete before CHECK, so the range test is ready when
  // the checksum byte arrives.
  assign pass = (byte_in == xor_q) && (k_sh_q != 16'd0) && (k_sh_q <= 16'(MAX_K));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    err_d   = 1'b0;
    drop_d  = drop_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_valid_in && (byte_in == SYNC)) begin
          state_d = ST_K;
          idx_d   = '0;
          xor_d   = 8'h00;
        end
      end
      ST_K: begin
        if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (byte_valid_in) begin
          xor_d = xor_q ^ byte_in;
          if (idx_q == IDX_KHI) begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (byte_valid_in) begin
          xor_d = xor_q ^ byte_in;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (byte_valid_in) begin
          if (pass) begin
            state_d = ST_PRESENT;
            commit  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        // Any byte here, SYNC included, is lost; the sender must wait.
        if (byte_valid_in && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 1'b1;
        end
        if (query_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q  <= '0;
      xor_q  <= 8'h00;
      err_q  <= 1'b0;
      drop_q <= 8'h00;
    end else begin
      idx_q  <= idx_d;
      xor_q  <= xor_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  // Shadow registers: filled while receiving, never visible until commit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k_sh_q <= 16'd0;
      for (int w = 0; w < DIM; w++) begin
        q_sh_q[w] <= '0;
      end
    end else begin
      if ((state_q == ST_K) && byte_valid_in && !expire) begin
        if (idx_q == '0) begin
          k_sh_q[7:0] <= byte_in;
        end else begin
          k_sh_q[15:8] <= byte_in;
        end
      end
      if ((state_q == ST_PAYLOAD) && byte_valid_in && !expire) begin
        for (int w = 0; w < DIM; w++) begin
          for (int b = 0; b < BPW; b++) begin
            if (idx_q == IDX_W'(w * BPW + b)) begin
              q_sh_q[w][8*b +: 8] <= byte_in;
            end
          end
        end
      end
    end
  end

  // Output registers: loaded only on the edge that enters PRESENT.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k_out_q <= 16'd0;
      for (int w = 0; w < DIM; w++) begin
        q_out_q[w] <= '0;
      end
    end else if (commit) begin
      k_out_q <= k_sh_q;
      for (int w = 0; w < DIM; w++) begin
        q_out_q[w] <= q_sh_q[w];
      end
    end
  end

  assign query_out       = q_out_q;
  assign k_out           = k_out_q;
  assign query_valid_out = (state_q == ST_PRESENT);
  assign busy_out        = in_frame;
  assign err_out         = err_q;
  assign drop_cnt_out    = drop_q;

endmodule

// File: tb/tb_query_loader.sv
// tb_query_loader
//   Frame-level bench for query_loader: a table of frames with their
//   expected accept/reject outcome, a scoreboard of committed queries popped
//   when query_valid_out rises, and hand-written hold, timeout and reset cases.
module tb_query_loader;

  localparam int DIM    = 4;
  localparam int WORD_W = 32;
  localparam int MAX_K  = 8;
  localparam int TO     = 40;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic [7:0]        byte_in    = 8'h00;
  logic              byte_valid = 1'b0;
  logic              ready      = 1'b0;
  logic [WORD_W-1:0] query_out [DIM];
  logic [15:0]       k_out;
  logic              valid;
  logic              busy;
  logic              err;
  logic [7:0]        drop;

  query_loader #(
    .DIM     (DIM),
    .WORD_W  (WORD_W),
    .MAX_K   (MAX_K),
    .SYNC    (8'hA5),
    .TIMEOUT (TO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid),
    .query_out       (query_out),
    .k_out           (k_out),
    .query_valid_out (valid),
    .query_ready_in  (ready),
    .busy_out        (busy),
    .err_out         (err),
    .drop_cnt_out    (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  k;
    logic [127:0] q;   // word 0 in [31:0]
    logic [7:0]   cx;  // XOR applied to the correct checksum (0 = good csum)
    bit           ok;  // frame must be committed
  } vec_t;

  typedef struct {
    logic [15:0]  k;
    logic [127:0] q;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         tbl[7];
  int           n_chk    = 0;
  int           n_fail   = 0;
  int           err_cnt  = 0;
  bit           vld_prev = 1'b0;
  logic [15:0]  last_k   = 16'd0;
  logic [127:0] last_q   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] cur_q();
    logic [127:0] r;
    for (int i = 0; i < DIM; i++) r[32*i +: 32] = query_out[i];
    return r;
  endfunction

  function automatic logic [7:0] frame_xor(input logic [15:0] k, input logic [127:0] q);
    logic [7:0] x;
    x = k[7:0] ^ k[15:8];
    for (int i = 0; i < 16; i++) x ^= q[8*i +: 8];
    return x;
  endfunction

  // One clock: inputs already driven, sample #1 after the edge, then run the
  // scoreboard monitor on a rising query_valid_out.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (err) err_cnt++;
    if (valid && !vld_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_commit", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("commit_k", k_out, e.k);
        chk("commit_query", cur_q(), e.q);
      end
    end
    vld_prev = valid;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [15:0] k, input logic [127:0] q,
                            input logic [7:0] csum, input bit push);
    exp_t e;
    send_byte(8'hA5);
    send_byte(k[7:0]);
    send_byte(k[15:8]);
    for (int i = 0; i < 16; i++) send_byte(q[8*i +: 8]);
    if (push) begin
      e.k = k;
      e.q = q;
      sb_q.push_back(e);
    end
    send_byte(csum);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    chk("valid_drop_after_ready", valid, 1'b0);
    chk("idle_after_ready", busy, 1'b0);
    ready = 1'b0;
  endtask

  initial begin
    logic [127:0] f1_q;
    logic [127:0] snap_q;
    logic [15:0]  snap_k;
    int           unstable;
    int           e0;
    int           err_at;
    logic         busy_before;
    logic         busy_at;

    f1_q = {32'h1, 32'h1, 32'h7, 32'h5};

    tbl[0] = '{k: 16'd4,      q: f1_q, cx: 8'h00, ok: 1'b1};
    tbl[1] = '{k: 16'd4,      q: f1_q, cx: 8'h01, ok: 1'b0};
    tbl[2] = '{k: 16'd8,      q: {32'hFFFFFFFF, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF}, cx: 8'h00, ok: 1'b1};
    tbl[3] = '{k: 16'd0,      q: f1_q, cx: 8'h00, ok: 1'b0};
    tbl[4] = '{k: 16'd9,      q: f1_q, cx: 8'h00, ok: 1'b0};
    tbl[5] = '{k: 16'd1,      q: {32'h4, 32'h3, 32'h2, 32'h1}, cx: 8'h00, ok: 1'b1};
    tbl[6] = '{k: 16'h0104,   q: f1_q, cx: 8'h00, ok: 1'b0};

    // Reset state
    #12;
    chk("rst_valid", valid, 1'b0);
    chk("rst_k", k_out, 16'd0);
    chk("rst_query", cur_q(), 128'd0);
    chk("rst_busy_err_drop", {busy, err, drop}, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    // Stray non-SYNC bytes in IDLE are ignored
    send_byte(8'h33);
    chk("idle_ignores_byte", busy, 1'b0);

    // Literal frame 1 checksum from the byte listing
    chk("frame1_csum", frame_xor(16'd4, f1_q), 8'h06);

    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].k, tbl[i].q, frame_xor(tbl[i].k, tbl[i].q) ^ tbl[i].cx, tbl[i].ok);
      chk($sformatf("vec%0d_valid", i), valid, tbl[i].ok);
      chk($sformatf("vec%0d_err", i), err, !tbl[i].ok);
      if (tbl[i].ok) begin
        accept();
        last_k = tbl[i].k;
        last_q = tbl[i].q;
      end else begin
        repeat (3) tick();
        chk($sformatf("vec%0d_err_once", i), err_cnt - e0, 1);
        chk($sformatf("vec%0d_k_held", i), k_out, last_k);
        chk($sformatf("vec%0d_q_held", i), cur_q(), last_q);
      end
    end

    // Hold in PRESENT with ready low; bytes arriving are dropped
    send_frame(16'd4, f1_q, 8'h06, 1'b1);
    snap_q   = cur_q();
    snap_k   = k_out;
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3)       send_byte(8'h11);
      else if (c == 8)  send_byte(8'hA5);
      else if (c == 12) send_byte(8'h22);
      else              tick();
      if (cur_q() !== snap_q || k_out !== snap_k || valid !== 1'b1 || busy !== 1'b0) unstable++;
    end
    chk("hold_stable", unstable, 0);
    chk("hold_drop_cnt", drop, 8'd3);
    accept();
    last_k = 16'd4;
    last_q = f1_q;

    // Timeout after 5 payload bytes
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    e0          = err_cnt;
    err_at      = -1;
    busy_before = 1'b0;
    busy_at     = 1'b1;
    for (int j = 1; j <= TO + 5; j++) begin
      tick();
      if (err && err_at < 0) err_at = j;
      if (j == TO - 1) busy_before = busy;
      if (j == TO) busy_at = busy;
    end
    chk("timeout_cycle", err_at, TO);
    chk("timeout_err_once", err_cnt - e0, 1);
    chk("timeout_busy_before", busy_before, 1'b1);
    chk("timeout_busy_falls", busy_at, 1'b0);
    chk("timeout_k_held", k_out, last_k);

    // Reset mid-PAYLOAD
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    rst_n = 1'b0;
    #3;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_k", k_out, 16'd0);
    chk("midrst_query", cur_q(), 128'd0);
    chk("midrst_busy_err_drop", {busy, err, drop}, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_frame(16'd4, f1_q, 8'h06, 1'b1);
    chk("post_rst_valid", valid, 1'b1);

    // Reset while presenting drops valid at once
    rst_n = 1'b0;
    #1;
    chk("present_rst_valid", valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    vld_prev = 1'b0;
    tick();

    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
